// File: rtl/ps2_keymap.sv
// PS/2 set-2 scan-code stream to Hack keyboard register, with CDC, prefix FSM and shift tracking.
// Optional caps-lock support is enabled by defining PS2_KEYMAP_CAPS_LOCK_EN.
module ps2_keymap #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        i_clock,
    input  logic        reset_n,
    input  logic        scan_ready,
    input  logic [7:0]  scan_code,
    output logic [15:0] key,
    output logic        key_strobe
);

    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    logic [SS-1:0] sync_q;
    logic          edge_q;
    logic          rise;
    logic [7:0]    byte_reg;
    logic          byte_valid;
    state_t        state;
    logic          shift;
    logic          caps;

    logic          is_ext;
    logic          is_brk;
    logic          is_e0;
    logic          is_f0;
    logic          is_shift_code;
    logic [7:0]    code_v;

    // Set-2 to Hack translation; returns 0 for unmapped codes.
    function automatic logic [7:0] xlate(input logic [7:0] code, input logic ext,
                                         input logic sh, input logic cp);
        logic [7:0] lo_v;
        logic [7:0] hi_v;
        logic       letter;
        lo_v   = 8'd0;
        hi_v   = 8'd0;
        letter = 1'b0;
        if (ext) begin
            case (code)
                8'h6B: lo_v = 8'd130;
                8'h75: lo_v = 8'd131;
                8'h74: lo_v = 8'd132;
                8'h72: lo_v = 8'd133;
                8'h6C: lo_v = 8'd134;
                8'h69: lo_v = 8'd135;
                8'h7D: lo_v = 8'd136;
                8'h7A: lo_v = 8'd137;
                8'h70: lo_v = 8'd138;
                8'h71: lo_v = 8'd139;
                default: lo_v = 8'd0;
            endcase
            hi_v = lo_v;
        end else begin
            case (code)
                8'h1C: begin lo_v = 8'd97;  letter = 1'b1; end
                8'h32: begin lo_v = 8'd98;  letter = 1'b1; end
                8'h21: begin lo_v = 8'd99;  letter = 1'b1; end
                8'h23: begin lo_v = 8'd100; letter = 1'b1; end
                8'h24: begin lo_v = 8'd101; letter = 1'b1; end
                8'h2B: begin lo_v = 8'd102; letter = 1'b1; end
                8'h34: begin lo_v = 8'd103; letter = 1'b1; end
                8'h33: begin lo_v = 8'd104; letter = 1'b1; end
                8'h43: begin lo_v = 8'd105; letter = 1'b1; end
                8'h3B: begin lo_v = 8'd106; letter = 1'b1; end
                8'h42: begin lo_v = 8'd107; letter = 1'b1; end
                8'h4B: begin lo_v = 8'd108; letter = 1'b1; end
                8'h3A: begin lo_v = 8'd109; letter = 1'b1; end
                8'h31: begin lo_v = 8'd110; letter = 1'b1; end
                8'h44: begin lo_v = 8'd111; letter = 1'b1; end
                8'h4D: begin lo_v = 8'd112; letter = 1'b1; end
                8'h15: begin lo_v = 8'd113; letter = 1'b1; end
                8'h2D: begin lo_v = 8'd114; letter = 1'b1; end
                8'h1B: begin lo_v = 8'd115; letter = 1'b1; end
                8'h2C: begin lo_v = 8'd116; letter = 1'b1; end
                8'h3C: begin lo_v = 8'd117; letter = 1'b1; end
                8'h2A: begin lo_v = 8'd118; letter = 1'b1; end
                8'h1D: begin lo_v = 8'd119; letter = 1'b1; end
                8'h22: begin lo_v = 8'd120; letter = 1'b1; end
                8'h35: begin lo_v = 8'd121; letter = 1'b1; end
                8'h1A: begin lo_v = 8'd122; letter = 1'b1; end
                8'h45: begin lo_v = 8'd48;  hi_v = 8'd41;  end
                8'h16: begin lo_v = 8'd49;  hi_v = 8'd33;  end
                8'h1E: begin lo_v = 8'd50;  hi_v = 8'd64;  end
                8'h26: begin lo_v = 8'd51;  hi_v = 8'd35;  end
                8'h25: begin lo_v = 8'd52;  hi_v = 8'd36;  end
                8'h2E: begin lo_v = 8'd53;  hi_v = 8'd37;  end
                8'h36: begin lo_v = 8'd54;  hi_v = 8'd94;  end
                8'h3D: begin lo_v = 8'd55;  hi_v = 8'd38;  end
                8'h3E: begin lo_v = 8'd56;  hi_v = 8'd42;  end
                8'h46: begin lo_v = 8'd57;  hi_v = 8'd40;  end
                8'h29: begin lo_v = 8'd32;  hi_v = 8'd32;  end
                8'h4E: begin lo_v = 8'd45;  hi_v = 8'd95;  end
                8'h55: begin lo_v = 8'd61;  hi_v = 8'd43;  end
                8'h41: begin lo_v = 8'd44;  hi_v = 8'd60;  end
                8'h49: begin lo_v = 8'd46;  hi_v = 8'd62;  end
                8'h4A: begin lo_v = 8'd47;  hi_v = 8'd63;  end
                8'h4C: begin lo_v = 8'd59;  hi_v = 8'd58;  end
                8'h52: begin lo_v = 8'd39;  hi_v = 8'd34;  end
                8'h54: begin lo_v = 8'd91;  hi_v = 8'd123; end
                8'h5B: begin lo_v = 8'd93;  hi_v = 8'd125; end
                8'h5D: begin lo_v = 8'd92;  hi_v = 8'd124; end
                8'h0E: begin lo_v = 8'd96;  hi_v = 8'd126; end
                8'h5A: begin lo_v = 8'd128; hi_v = 8'd128; end
                8'h66: begin lo_v = 8'd129; hi_v = 8'd129; end
                8'h76: begin lo_v = 8'd140; hi_v = 8'd140; end
                8'h05: begin lo_v = 8'd141; hi_v = 8'd141; end
                8'h06: begin lo_v = 8'd142; hi_v = 8'd142; end
                8'h04: begin lo_v = 8'd143; hi_v = 8'd143; end
                8'h0C: begin lo_v = 8'd144; hi_v = 8'd144; end
                8'h03: begin lo_v = 8'd145; hi_v = 8'd145; end
                8'h0B: begin lo_v = 8'd146; hi_v = 8'd146; end
                8'h83: begin lo_v = 8'd147; hi_v = 8'd147; end
                8'h0A: begin lo_v = 8'd148; hi_v = 8'd148; end
                8'h01: begin lo_v = 8'd149; hi_v = 8'd149; end
                8'h09: begin lo_v = 8'd150; hi_v = 8'd150; end
                8'h78: begin lo_v = 8'd151; hi_v = 8'd151; end
                8'h07: begin lo_v = 8'd152; hi_v = 8'd152; end
                default: begin lo_v = 8'd0; hi_v = 8'd0; end
            endcase
            if (letter) begin
                hi_v = lo_v - 8'd32;
            end
        end
        return ((letter ? (sh ^ cp) : sh) ? hi_v : lo_v);
    endfunction

    assign rise = sync_q[SS-1] & ~edge_q;

    // Synchronize scan_ready, detect its rising edge and capture the byte.
    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            edge_q     <= 1'b0;
            byte_reg   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SS-2:0], scan_ready};
            edge_q     <= sync_q[SS-1];
            byte_valid <= rise;
            if (rise) begin
                byte_reg <= scan_code;
            end
        end
    end

    always_comb begin
        is_ext        = (state == EXT) || (state == EXT_BRK);
        is_brk        = (state == BRK) || (state == EXT_BRK);
        is_e0         = (byte_reg == 8'hE0);
        is_f0         = (byte_reg == 8'hF0);
        is_shift_code = !is_ext && ((byte_reg == 8'h12) || (byte_reg == 8'h59));
        code_v        = xlate(byte_reg, is_ext, shift, caps);
    end

    // Prefix FSM with make/break handling; key and strobe are registered.
    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= 1'b0;
            key        <= 16'h0000;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (byte_valid) begin
                if (is_e0) begin
                    if (state == IDLE || state == EXT) begin
                        state <= EXT;
                    end
                end else if (is_f0) begin
                    case (state)
                        IDLE:    state <= BRK;
                        EXT:     state <= EXT_BRK;
                        default: state <= state;
                    endcase
                end else begin
                    state <= IDLE;
                    if (!is_brk) begin
                        if (is_shift_code) begin
                            shift <= 1'b1;
                        end else if (code_v != 8'd0) begin
                            key        <= {8'h00, code_v};
                            key_strobe <= 1'b1;
                        end
                    end else begin
                        if (is_shift_code) begin
                            shift <= 1'b0;
                        end else if ((code_v != 8'd0) && ({8'h00, code_v} == key)) begin
                            key <= 16'h0000;
                        end
                    end
                end
            end
        end
    end

`ifdef PS2_KEYMAP_CAPS_LOCK_EN
    // Caps lock toggles on each normal make of 58.
    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            caps <= 1'b0;
        end else if (byte_valid && (state == IDLE) && (byte_reg == 8'h58)) begin
            caps <= ~caps;
        end
    end
`else
    assign caps = 1'b0;
`endif

endmodule
